// File: rtl/uart_rx_block.sv
// -----------------------------------------------------------------------------
// uart_rx_block
// UART receiver for 8N1 frames (1 start, 8 data bits LSB first, 1 stop),
// recovered with an internally generated OVERSAMPLE-times-per-bit tick.
// Optional macro UART_RX_PARITY_EN turns the frame into 8E1 (even parity).
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   rx_in       asynchronous serial line, idle high
//   m_data      last correctly received byte (held until the next good frame)
//   valid       one-cycle pulse, m_data updated in the same cycle
//   frame_err   one-cycle pulse, stop bit sampled low
//   parity_err  one-cycle pulse, parity mismatch (constant 0 without the macro)
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_block #(
   parameter int CLK_FREQ   = 44000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] m_data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   // Rounded clk cycles per oversample tick.
   localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW    = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] TCNT_LAST = DIV_W'(DIV - 1);
   localparam logic [SW-1:0]    SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0]    SCNT_LAST = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      ST_PARITY    = 3'd5
`endif
   } state_t;

`ifdef UART_RX_PARITY_EN
   // Even parity: data bits plus parity bit must XOR to 0.
   function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction
`endif

   state_t           state_r, state_n;
   logic             rx_meta_r, rx_s_r;
   logic [DIV_W-1:0] tcnt_r, tcnt_n;
   logic [SW-1:0]    scnt_r, scnt_n;
   logic [2:0]       bcnt_r, bcnt_n;
   logic [7:0]       shift_r, shift_n;
   logic [7:0]       m_data_r, m_data_n;
   logic             valid_r, valid_n;
   logic             frame_err_r, frame_err_n;
   logic             busy_r, busy_n;
   logic             tick_s;
`ifdef UART_RX_PARITY_EN
   logic             par_r, par_n;
   logic             parity_err_r, parity_err_n;
`endif

   assign tick_s = (tcnt_r == TCNT_LAST);

   // Synchroniser and all state/output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r    <= 1'b1;
         rx_s_r       <= 1'b1;
         state_r      <= ST_IDLE;
         tcnt_r       <= '0;
         scnt_r       <= '0;
         bcnt_r       <= 3'd0;
         shift_r      <= 8'h00;
         m_data_r     <= 8'h00;
         valid_r      <= 1'b0;
         frame_err_r  <= 1'b0;
         busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r        <= 1'b0;
         parity_err_r <= 1'b0;
`endif
      end else begin
         rx_meta_r    <= rx_in;
         rx_s_r       <= rx_meta_r;
         state_r      <= state_n;
         tcnt_r       <= tcnt_n;
         scnt_r       <= scnt_n;
         bcnt_r       <= bcnt_n;
         shift_r      <= shift_n;
         m_data_r     <= m_data_n;
         valid_r      <= valid_n;
         frame_err_r  <= frame_err_n;
         busy_r       <= busy_n;
`ifdef UART_RX_PARITY_EN
         par_r        <= par_n;
         parity_err_r <= parity_err_n;
`endif
      end
   end

   // Next-state, counter and output-pulse logic.
   always_comb begin
      state_n     = state_r;
      tcnt_n      = tick_s ? '0 : tcnt_r + DIV_W'(1);
      // OVERSAMPLE is a power of two, so the sample counter wraps naturally.
      scnt_n      = tick_s ? scnt_r + SW'(1) : scnt_r;
      bcnt_n      = bcnt_r;
      shift_n     = shift_r;
      m_data_n    = m_data_r;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n        = par_r;
      parity_err_n = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (!rx_s_r) begin
               // Restart the tick phase at the start edge.
               state_n = ST_START;
               tcnt_n  = '0;
               scnt_n  = '0;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s && (scnt_r == SCNT_MID)) begin
               if (rx_s_r) begin
                  state_n = ST_IDLE;            // glitch, not a real start bit
               end else begin
                  state_n = ST_DATA;
                  scnt_n  = '0;
                  bcnt_n  = 3'd0;
               end
            end else begin
               state_n = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s && (scnt_r == SCNT_LAST)) begin
               shift_n = {rx_s_r, shift_r[7:1]};
               if (bcnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
                  bcnt_n  = 3'd0;
               end else begin
                  bcnt_n  = bcnt_r + 3'd1;
               end
            end else begin
               state_n = ST_DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick_s && (scnt_r == SCNT_LAST)) begin
               par_n   = rx_s_r;
               state_n = ST_STOP;
            end else begin
               state_n = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tick_s && (scnt_r == SCNT_LAST)) begin
               if (rx_s_r) begin
                  state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (even_parity_bad(shift_r, par_r)) begin
                     parity_err_n = 1'b1;
                  end else begin
                     valid_n  = 1'b1;
                     m_data_n = shift_r;
                  end
`else
                  valid_n  = 1'b1;
                  m_data_n = shift_r;
`endif
               end else begin
                  // A bad stop bit wins over any parity problem.
                  state_n     = ST_WAIT_IDLE;
                  frame_err_n = 1'b1;
               end
            end else begin
               state_n = ST_STOP;
            end
         end
         ST_WAIT_IDLE: begin
            if (tick_s && rx_s_r) begin
               state_n = ST_IDLE;
            end else begin
               state_n = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      busy_n = (state_n != ST_IDLE);
   end

   assign m_data    = m_data_r;
   assign valid     = valid_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_r;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_block.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_block
// Directed bench for uart_rx_block at 6.4 MHz / 100 kbaud (64 clk per bit).
// -----------------------------------------------------------------------------
module tb_uart_rx_block;

   localparam int BIT_CLK = 64;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [7:0] m_data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Event recorder, written only here.
   int         valid_cnt = 0;
   int         ferr_cnt  = 0;
   int         perr_cnt  = 0;
   logic [7:0] vq[$];
   logic       prev_busy = 1'b0;
   logic       busy_at_valid = 1'b1;
   logic       prev_busy_at_valid = 1'b0;

`ifdef UART_RX_PARITY_EN
   logic force_bad_par = 1'b0;
`endif

   uart_rx_block #(
      .CLK_FREQ  (6400000),
      .BAUD      (100000),
      .OVERSAMPLE(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_in),
      .m_data    (m_data),
      .valid     (valid),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         valid_cnt++;
         vq.push_back(m_data);
         busy_at_valid = busy;
         prev_busy_at_valid = prev_busy;
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (parity_err === 1'b1) perr_cnt++;
      prev_busy = busy;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      wait_clk(BIT_CLK);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^data ^ force_bad_par);
`endif
      send_bit(stop_bit);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_in = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(1);
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h want 00", m_data); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_good_frame();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      int p0 = perr_cnt;
      send_frame(8'hA5, 1'b1);
      wait_clk(32);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL good_valid_count got %0d want 1", valid_cnt - v0); end
      checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL good_m_data got %h want a5", m_data); end
      checks++; if (ferr_cnt - f0 != 0 || perr_cnt - p0 != 0) begin errors++; $display("FAIL good_no_err got %0d/%0d want 0/0", ferr_cnt - f0, perr_cnt - p0); end
      checks++; if (busy_at_valid !== 1'b0 || prev_busy_at_valid !== 1'b1) begin errors++; $display("FAIL good_busy_edge got %b%b want 10", prev_busy_at_valid, busy_at_valid); end
   endtask

   task automatic test_glitch();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      rx_in = 1'b0;
      wait_clk(20);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b want 1", busy); end
      rx_in = 1'b1;
      wait_clk(100);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got %b want 0", busy); end
      checks++; if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0) begin errors++; $display("FAIL glitch_no_pulse got %0d/%0d want 0/0", valid_cnt - v0, ferr_cnt - f0); end
   endtask

   task automatic test_frame_err();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0);
      wait_clk(200);
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
      checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL ferr_no_valid got %0d want 0", valid_cnt - v0); end
      checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL ferr_m_data_held got %h want a5", m_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_during_break got %b want 1", busy); end
      rx_in = 1'b1;
      wait_clk(1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_after_release got %b want 1", busy); end
      wait_clk(20);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_idle got %b want 0", busy); end
      checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_single_pulse got %0d want 1", ferr_cnt - f0); end
   endtask

   task automatic test_back_to_back();
      int v0 = valid_cnt;
      int f0 = ferr_cnt;
      int q0 = vq.size();
      wait_clk(40);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_clk(16);
      checks++; if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", valid_cnt - v0); end
      if (vq.size() >= q0 + 2) begin
         checks++; if (vq[q0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", vq[q0]); end
         checks++; if (vq[q0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", vq[q0+1]); end
      end else begin
         checks++; errors++; $display("FAIL b2b_capture got %0d bytes want 2", vq.size() - q0);
      end
      // Third frame cut short by reset.
      v0 = valid_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      wait_clk(20);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid_frame got %b want 1", busy); end
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after_rst got %b want 0", busy); end
      wait_clk(700);
      checks++; if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0) begin errors++; $display("FAIL b2b_no_pulse_after_rst got %0d/%0d want 0/0", valid_cnt - v0, ferr_cnt - f0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_final got %b want 0", busy); end
      checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL b2b_m_data_reset got %h want 00", m_data); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0 = valid_cnt;
      int p0 = perr_cnt;
      force_bad_par = 1'b0;
      send_frame(8'h81, 1'b1);
      wait_clk(16);
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL par_good_valid got %0d want 1", valid_cnt - v0); end
      checks++; if (m_data !== 8'h81) begin errors++; $display("FAIL par_good_m_data got %h want 81", m_data); end
      v0 = valid_cnt;
      force_bad_par = 1'b1;
      send_frame(8'h81, 1'b1);
      force_bad_par = 1'b0;
      wait_clk(16);
      checks++; if (perr_cnt - p0 != 1) begin errors++; $display("FAIL par_bad_pulse got %0d want 1", perr_cnt - p0); end
      checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL par_bad_no_valid got %0d want 0", valid_cnt - v0); end
      checks++; if (m_data !== 8'h81) begin errors++; $display("FAIL par_bad_m_data got %h want 81", m_data); end
   endtask
`else
   task automatic test_parity();
      checks++; if (perr_cnt != 0) begin errors++; $display("FAIL par_tied_low got %0d pulses want 0", perr_cnt); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      rx_in = 1'b1;
      test_reset();
      test_good_frame();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_parity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
